// File: rtl/imem_program_loader_pkg.sv
// imem_program_loader_pkg: shared loader state encoding, default widths and the MIPS no-op word.
package imem_program_loader_pkg;
   typedef enum logic [1:0] {LOAD, RELEASE, RUN, HALT} state_t;
   localparam int DEF_ADDR_W = 8;
   localparam int DEF_DATA_W = 32;
   localparam logic [31:0] MIPS_NOP = 32'h0000_0000;
endpackage

// File: rtl/imem_program_loader_if.sv
// imem_program_loader_if: program word stream plus instruction memory write bus.
// Ports (signals): in_valid/in_data/in_last/in_ready form the source handshake;
// imem_we/imem_addr/imem_wdata form the instruction memory write port.
// master = program source side, slave = loader side.
interface imem_program_loader_if
   import imem_program_loader_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_last;
   logic              in_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [DATA_W-1:0] imem_wdata;
   modport master (output in_valid, in_data, in_last, input in_ready, imem_we, imem_addr, imem_wdata);
   modport slave  (input in_valid, in_data, in_last, output in_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/imem_program_loader_run_budget_counter.sv
// imem_program_loader_run_budget_counter: 32-bit core run-cycle counter with terminal compare.
// Ports: clk, rst_n (sync active-low), clr (sync clear), en (count enable),
// count (cycles counted), term (count has reached MAX_CYCLES-1).
module imem_program_loader_run_budget_counter #(
   parameter int MAX_CYCLES = 26
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        en,
   output logic [31:0] count,
   output logic        term
);
   assign term = count == 32'(MAX_CYCLES - 1);
   always_ff @(posedge clk)
      if (!rst_n || clr) count <= '0;
      else if (en) count <= count + 32'd1;
endmodule

// File: rtl/imem_program_loader.sv
// imem_program_loader: streams a program into instruction memory, then releases and runs the core for a bounded time.
// Ports: clk, rst_n (sync active-low), reload (restart loading at address 0),
// bus (slave: word stream in, imem write port out), core_rst_n / core_run (core reset and clock enable),
// halted (run budget exhausted), overflow (program longer than DEPTH, sticky),
// load_count (words written in the last load), run_cycles (cycles since core release).
module imem_program_loader
   import imem_program_loader_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DEPTH      = 256,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int MAX_CYCLES = 26
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                reload,
   imem_program_loader_if.slave bus,
   output logic                core_rst_n,
   output logic                core_run,
   output logic                halted,
   output logic                overflow,
   output logic [ADDR_W:0]     load_count,
   output logic [31:0]         run_cycles
);
   state_t            st;
   logic              hs;
   logic              term;
   logic [DATA_W-1:0] word;
   // reload and reset both refuse words combinationally so a coincident offer is never taken
   assign bus.in_ready = (st == LOAD) && !reload && rst_n;
   assign hs           = bus.in_valid && bus.in_ready;
   assign word         = bus.in_data;
   imem_program_loader_run_budget_counter #(.MAX_CYCLES(MAX_CYCLES)) u_budget (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (reload),
      .en    (st == RUN),
      .count (run_cycles),
      .term  (term)
   );
   always_ff @(posedge clk) begin
      bus.imem_we <= hs;
      if (!rst_n) begin
         bus.imem_addr  <= '0;
         bus.imem_wdata <= '0;
      end else if (hs) begin
         bus.imem_addr  <= load_count[ADDR_W-1:0];
         bus.imem_wdata <= word;
      end
      if (!rst_n || reload) begin
         st         <= LOAD;
         load_count <= '0;
         core_rst_n <= 1'b0;
         core_run   <= 1'b0;
         halted     <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         case (st)
            LOAD:
               if (hs) begin
                  load_count <= load_count + 1'b1;
                  // the last slot ends the load even without in_last; that case is an overflow
                  if (bus.in_last || load_count == (ADDR_W+1)'(DEPTH - 1)) begin
                     st       <= RELEASE;
                     overflow <= !bus.in_last;
                  end
               end
            RELEASE: begin
               st         <= RUN;
               core_rst_n <= 1'b1;
               core_run   <= 1'b1;
            end
            RUN:
               if (term) begin
                  st       <= HALT;
                  core_run <= 1'b0;
                  halted   <= 1'b1;
               end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_imem_program_loader.sv
// tb_imem_program_loader: directed self-checking bench for imem_program_loader (default and DEPTH=4 instances).
module tb_imem_program_loader;
   import imem_program_loader_pkg::*;
   logic        clk = 1'b0, rst_n = 1'b0, reload = 1'b0;
   logic        core_rst_n, core_run, halted, overflow;
   logic        c1_rst_n, c1_run, h1, ov1;
   logic [8:0]  load_count, lc1;
   logic [31:0] run_cycles, rc1;
   int          checks = 0, failures = 0, cyc = 0, idx;
   logic        acc;
   logic [31:0] a0[$], d0[$], a1[$], d1[$];
   int          c0[$];
   logic [31:0] prog[4] = '{32'h2008_0005, 32'h2009_0003, 32'h0109_5020, 32'h0000_0000};
   logic [31:0] gw[3]   = '{32'h1111_0001, 32'h1111_0002, 32'h1111_0003};
   logic [31:0] nw[2]   = '{32'hAAAA_0001, 32'hAAAA_0002};
   logic [31:0] ow[6];

   imem_program_loader_if b0 ();
   imem_program_loader_if b1 ();

   imem_program_loader dut (
      .clk(clk), .rst_n(rst_n), .reload(reload), .bus(b0),
      .core_rst_n(core_rst_n), .core_run(core_run), .halted(halted), .overflow(overflow),
      .load_count(load_count), .run_cycles(run_cycles)
   );
   imem_program_loader #(.DEPTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .reload(1'b0), .bus(b1),
      .core_rst_n(c1_rst_n), .core_run(c1_run), .halted(h1), .overflow(ov1),
      .load_count(lc1), .run_cycles(rc1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (b0.imem_we) begin
         a0.push_back(32'(b0.imem_addr));
         d0.push_back(b0.imem_wdata);
         c0.push_back(cyc);
      end
      if (b1.imem_we) begin
         a1.push_back(32'(b1.imem_addr));
         d1.push_back(b1.imem_wdata);
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_we"}, 32'(b0.imem_we), 0);
      chk({tag, "_addr"}, 32'(b0.imem_addr), 0);
      chk({tag, "_wdata"}, b0.imem_wdata, 0);
      chk({tag, "_core_rst_n"}, 32'(core_rst_n), 0);
      chk({tag, "_core_run"}, 32'(core_run), 0);
      chk({tag, "_halted"}, 32'(halted), 0);
      chk({tag, "_overflow"}, 32'(overflow), 0);
      chk({tag, "_load_count"}, 32'(load_count), 0);
      chk({tag, "_run_cycles"}, run_cycles, 0);
   endtask

   initial begin
      for (int i = 0; i < 6; i++) ow[i] = (i == 0) ? MIPS_NOP : 32'h2400_0000 + 32'(i);
      b0.in_valid = 0; b0.in_data = 0; b0.in_last = 0;
      b1.in_valid = 0; b1.in_data = 0; b1.in_last = 0;
      tick; tick;
      chk("rst_ready", 32'(b0.in_ready), 0);
      chk_reset_vals("rst");
      rst_n = 1;
      #1 chk("ready_after_rst", 32'(b0.in_ready), 1);

      // 4-word load, valid held high
      for (int i = 0; i < 4; i++) begin
         b0.in_valid = 1; b0.in_data = prog[i]; b0.in_last = (i == 3); tick;
      end
      b0.in_valid = 0; b0.in_last = 0;
      chk("t1_ready_release", 32'(b0.in_ready), 0);
      chk("t1_rstn_release", 32'(core_rst_n), 0);
      chk("t1_load_count", 32'(load_count), 4);
      chk("t1_last_we", 32'(b0.imem_we), 1);
      chk("t1_last_addr", 32'(b0.imem_addr), 3);
      tick;
      chk("t1_rstn_rise", 32'(core_rst_n), 1);
      chk("t1_core_run", 32'(core_run), 1);
      chk("t1_run0", run_cycles, 0);
      repeat (25) tick;
      chk("t1_run25", run_cycles, 25);
      chk("t1_not_halted", 32'(halted), 0);
      tick;
      chk("t1_halted", 32'(halted), 1);
      chk("t1_run26", run_cycles, 26);
      chk("t1_run_off", 32'(core_run), 0);
      chk("t1_rstn_hold", 32'(core_rst_n), 1);
      repeat (3) tick;
      chk("t1_frozen", run_cycles, 26);
      chk("t1_nwrites", a0.size(), 4);
      for (int i = 0; i < 4 && i < a0.size(); i++) begin
         chk("t1_waddr", a0[i], i);
         chk("t1_wdata", d0[i], prog[i]);
         chk("t1_wcycle", c0[i], c0[0] + i);
      end
      a0.delete(); d0.delete(); c0.delete();

      // overflow on DEPTH=4 instance, 6 words offered without in_last
      idx = 0;
      b1.in_valid = 1; b1.in_last = 0;
      for (int i = 0; i < 6; i++) begin
         b1.in_data = ow[idx];
         acc = b1.in_ready;
         tick;
         if (acc) idx++;
      end
      b1.in_valid = 0;
      chk("ov_accepted", idx, 4);
      chk("ov_flag", 32'(ov1), 1);
      chk("ov_load_count", 32'(lc1), 4);
      chk("ov_released", 32'(c1_rst_n), 1);
      chk("ov_run1", rc1, 1);
      chk("ov_nwrites", a1.size(), 4);
      for (int i = 0; i < 4 && i < a1.size(); i++) begin
         chk("ov_waddr", a1[i], i);
         chk("ov_wdata", d1[i], ow[i]);
      end

      // reload out of HALT, then gapped load
      reload = 1; tick; reload = 0;
      #1 chk("rl_ready", 32'(b0.in_ready), 1);
      chk("rl_halted", 32'(halted), 0);
      chk("rl_run", run_cycles, 0);
      for (int k = 0; k < 3; k++) begin
         b0.in_valid = 0; tick; tick;
         b0.in_valid = 1; b0.in_data = gw[k]; b0.in_last = (k == 2); tick;
      end
      b0.in_valid = 0; b0.in_last = 0;
      #1 chk("gap_ready_after_last", 32'(b0.in_ready), 0);
      chk("gap_load_count", 32'(load_count), 3);
      tick;
      chk("gap_nwrites", a0.size(), 3);
      for (int i = 0; i < 3 && i < a0.size(); i++) begin
         chk("gap_waddr", a0[i], i);
         chk("gap_wdata", d0[i], gw[i]);
      end
      a0.delete(); d0.delete(); c0.delete();

      // reload pulse at run_cycles=10
      repeat (10) tick;
      chk("ab_run10", run_cycles, 10);
      reload = 1; tick; reload = 0;
      #1 chk("ab_ready", 32'(b0.in_ready), 1);
      chk("ab_rstn", 32'(core_rst_n), 0);
      chk("ab_core_run", 32'(core_run), 0);
      chk("ab_run0", run_cycles, 0);
      chk("ab_halted", 32'(halted), 0);
      chk("ab_load_count", 32'(load_count), 0);
      for (int i = 0; i < 2; i++) begin
         b0.in_valid = 1; b0.in_data = nw[i]; b0.in_last = (i == 1); tick;
      end
      b0.in_valid = 0; b0.in_last = 0;
      tick;
      chk("ab2_rstn", 32'(core_rst_n), 1);
      chk("ab2_run0", run_cycles, 0);
      repeat (25) tick;
      chk("ab2_not_halted", 32'(halted), 0);
      tick;
      chk("ab2_halted", 32'(halted), 1);
      chk("ab2_run26", run_cycles, 26);
      chk("ab2_nwrites", a0.size(), 2);
      for (int i = 0; i < 2 && i < a0.size(); i++) begin
         chk("ab2_waddr", a0[i], i);
         chk("ab2_wdata", d0[i], nw[i]);
      end
      a0.delete(); d0.delete(); c0.delete();

      // reload coincident with in_valid in LOAD
      reload = 1; tick; reload = 0;
      reload = 1; b0.in_valid = 1; b0.in_data = 32'h1234_5678; b0.in_last = 0;
      #1 chk("co_ready", 32'(b0.in_ready), 0);
      tick; reload = 0;
      #1 chk("co_we", 32'(b0.imem_we), 0);
      chk("co_ptr", 32'(load_count), 0);
      tick;
      chk("co_we_next", 32'(b0.imem_we), 1);
      chk("co_addr_next", 32'(b0.imem_addr), 0);
      chk("co_wdata_next", b0.imem_wdata, 32'h1234_5678);
      b0.in_data = 32'h9ABC_DEF0; tick;
      chk("co_addr2", 32'(b0.imem_addr), 1);
      chk("co_count2", 32'(load_count), 2);

      // rst_n low for one cycle mid-load
      b0.in_valid = 0; rst_n = 0;
      #1 chk("mr_ready", 32'(b0.in_ready), 0);
      tick;
      chk_reset_vals("mr");
      rst_n = 1;
      a0.delete(); d0.delete(); c0.delete();
      b0.in_valid = 1; b0.in_data = 32'hCAFE_0001; b0.in_last = 1; tick;
      b0.in_valid = 0; b0.in_last = 0;
      chk("mr_we", 32'(b0.imem_we), 1);
      chk("mr_addr", 32'(b0.imem_addr), 0);
      chk("mr_wdata", b0.imem_wdata, 32'hCAFE_0001);
      chk("mr_count", 32'(load_count), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Writer-side counterpart to the pipeline's instruction fetch.
- Streams a program into instruction memory over a valid/ready word interface while holding the MIPS core in reset.
- Releases the core once loading is done, then runs it for a bounded number of cycles and halts it.
- Sits between the external program source and the MIPS_Pipeline instance, replacing hand-driven reset and cycle-limit logic.

Parameters:
ADDR_W, 8, instruction memory word-address width
DEPTH, 256, instruction memory depth in words; must be at most 2**ADDR_W
DATA_W, 32, instruction word width
MAX_CYCLES, 26, core run budget in cycles after release; must be at least 1

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
reload  input  1  single-cycle request to restart loading from address 0
in_valid  input  1  source presents a word
in_data  input  DATA_W  instruction word
in_last  input  1  marks the final word of the program
in_ready  output  1  loader accepts a word this cycle
imem_we  output  1  instruction memory write enable
imem_addr  output  ADDR_W  instruction memory word address
imem_wdata  output  DATA_W  instruction memory write data
core_rst_n  output  1  reset to MIPS core, synchronous active-low
core_run  output  1  clock enable to MIPS core
halted  output  1  run budget exhausted
overflow  output  1  program exceeded DEPTH words; sticky until reload or reset
load_count  output  ADDR_W+1  number of words written in the last load
run_cycles  output  32  cycles elapsed since core release

Behaviour:
- Reset is one clock and synchronous: rst_n low at a rising edge forces state LOAD.
- Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst_n=0, core_run=0, halted=0, overflow=0, load_count=0, run_cycles=0, word pointer=0.
- States: LOAD, RELEASE, RUN, HALT.
- in_ready is combinational: in_ready = (state==LOAD) && !reload && rst_n.
- Handshake: a word transfers when in_valid && in_ready at a rising edge.
- Write latency is 1 cycle. The cycle after a handshake, imem_we=1, imem_addr=pointer, imem_wdata=captured word. Otherwise imem_we=0.
- Pointer increments per handshake; load_count tracks words accepted.
- LOAD -> RELEASE on a handshake with in_last=1, or on a handshake at pointer==DEPTH-1 with in_last=0. In the second case, overflow is set and further words are refused.
- in_valid with in_ready=0 never writes. The source must hold its word until it is accepted.
- RELEASE lasts one cycle and waits for the final imem write to complete. core_rst_n stays 0.
- RELEASE -> RUN. In RUN, core_rst_n=1, core_run=1, and run_cycles increments by 1 each cycle, starting at 0 on the first RUN cycle.
- RUN -> HALT at the edge where run_cycles==MAX_CYCLES-1.
- HALT: core_run=0, core_rst_n=1 so core state stays observable, halted=1, run_cycles frozen at MAX_CYCLES.
- reload=1 in any state, at the next edge: state=LOAD, pointer=0, load_count=0, run_cycles=0, core_rst_n=0, core_run=0, halted=0, overflow=0.
- A coincident in_valid on a reload cycle is not accepted, because in_ready is already 0.
- Simultaneous rst_n=0 and reload: reset wins; the end result is identical.
- A reload or rst_n during RUN aborts the run immediately. Instruction memory contents are not cleared.
- A zero-length program is impossible: in_last always accompanies a real word.

Decomposition:
- Shared package holds the state enum (LOAD, RELEASE, RUN, HALT), the default ADDR_W/DATA_W, and a MIPS_NOP constant for bench fill.
- One natural sub-module: run_budget_counter. It is a 32-bit counter with enable, clear, and terminal compare against MAX_CYCLES-1. It drives both run_cycles and the RUN->HALT transition.

Test Plan:
- 4-word load (0x20080005, 0x20090003, 0x01095020, last 0x00000000), in_valid held high:
  - imem writes at addresses 0..3 on 4 consecutive cycles, 1 cycle after each accept;
  - load_count=4;
  - core_rst_n rises 2 cycles after the last accept;
  - halted=1 exactly 26 cycles later with run_cycles=26.
- Gapped valid, words offered every 3rd cycle, in_last on the 3rd word:
  - exactly 3 writes, at addresses 0,1,2;
  - in_ready=0 after the final accept.
- Overflow with DEPTH=4, 6 words offered with no in_last:
  - 4 writes at addresses 0..3, overflow=1, load_count=4;
  - the 5th word is never accepted;
  - the core is released normally.
- reload pulse at run_cycles=10:
  - next cycle state=LOAD, core_rst_n=0, run_cycles=0, halted=0, in_ready=1;
  - a new 2-word load then runs a full 26 cycles.
- reload coincident with in_valid in LOAD:
  - in_ready=0 that cycle, no imem write, pointer=0;
  - the same word offered on the next cycle is written to address 0.
- rst_n low for 1 cycle mid-load after 2 words:
  - all outputs return to their reset values;
  - the next load starts at address 0.
